// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state and BCD digit limits for countdown_timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD down-counting digit with clamped load and borrow out
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] cnt,
  output logic       brw_nxt
);
  assign brw_nxt = en && cnt == 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 4'd0;
    else if (ld) cnt <= ld_val > MAX ? MAX : ld_val;
    else if (en) cnt <= cnt == 4'd0 ? MAX : cnt - 4'd1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss BCD countdown with start/stop/pause, expiry pulse and alarm
module countdown_timer
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        stop,
  input  logic        ack,
  output logic [15:0] cnt,
  output logic        running,
  output logic        expired,
  output logic        buzz
);
  state_t state, nxt;
  logic ld, dec;
  logic [3:0] en, brw;
  logic brw_unused;
  assign ld = load && state != RUN;
  assign dec = state == RUN && tick && !stop;
  assign en = {brw[2:0], dec};
  assign brw_unused = brw[3];
  for (genvar d = 0; d < 4; d++) begin : g_dig
    bcd_down_digit #(.MAX((d % 2 == 1) ? TENS_MAX : ONES_MAX)) u_dig (
      .clk(clk),
      .rst_n(rst_n),
      .en(en[d]),
      .ld(ld),
      .ld_val(load_val[4*d +: 4]),
      .cnt(cnt[4*d +: 4]),
      .brw_nxt(brw[d])
    );
  end
  // stop dominates start; load in IDLE/PAUSE holds state so a simultaneous start is dropped
  always_comb
    nxt = state == RUN  ? (stop ? PAUSE : (tick && cnt == 16'h0001) ? DONE : RUN)
        : state == DONE ? ((ack || load) ? IDLE : DONE)
        : (stop || load) ? state
        : (start && cnt != 16'h0000) ? RUN : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
      buzz <= 1'b0;
    end else begin
      state <= nxt;
      running <= nxt == RUN;
      expired <= nxt == DONE && state != DONE;
      buzz <= nxt == DONE;
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench using a seconds-based reference model
module tb_countdown_timer;
  logic clk = 0, rst_n = 1, tick = 0, load = 0, start = 0, stop = 0, ack = 0;
  logic [15:0] load_val = 0;
  logic [15:0] cnt;
  logic running, expired, buzz;
  logic exp_d = 0;
  int n_cmp = 0, n_bad = 0;
  int m_st = 0, m_sec = 0;
  typedef struct {logic [15:0] cnt; logic running; logic expired; logic buzz; string tag;} exp_t;
  exp_t q[$];

  always #10 clk = ~clk;

  countdown_timer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .ack(ack),
    .cnt(cnt), .running(running), .expired(expired), .buzz(buzz)
  );

  function automatic logic [15:0] to_bcd(int s);
    int m = s / 60, c = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int clamp_sec(logic [15:0] v);
    int mt = v[15:12] > 4'd5 ? 5 : int'(v[15:12]);
    int mo = v[11:8] > 4'd9 ? 9 : int'(v[11:8]);
    int st = v[7:4] > 4'd5 ? 5 : int'(v[7:4]);
    int so = v[3:0] > 4'd9 ? 9 : int'(v[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(string tag, logic t, logic l, logic [15:0] lv, logic s, logic p, logic a);
    exp_t e;
    int prev = m_st;
    @(negedge clk);
    tick = t; load = l; load_val = lv; start = s; stop = p; ack = a;
    case (m_st)
      1: if (p) m_st = 2; else if (t) begin m_sec--; if (m_sec == 0) m_st = 3; end
      3: if (a || l) begin m_st = 0; if (l) m_sec = clamp_sec(lv); end
      default: if (l) m_sec = clamp_sec(lv); else if (!p && s && m_sec != 0) m_st = 1;
    endcase
    e.cnt = to_bcd(m_sec);
    e.running = m_st == 1;
    e.expired = m_st == 3 && prev != 3;
    e.buzz = m_st == 3;
    e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({e.tag, ".cnt"}, cnt, e.cnt);
    check({e.tag, ".running"}, {15'd0, running}, {15'd0, e.running});
    check({e.tag, ".expired"}, {15'd0, expired}, {15'd0, e.expired});
    check({e.tag, ".buzz"}, {15'd0, buzz}, {15'd0, e.buzz});
    tick = 0; load = 0; start = 0; stop = 0; ack = 0;
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    check({tag, ".cnt"}, cnt, 16'h0000);
    check({tag, ".running"}, {15'd0, running}, 16'd0);
    check({tag, ".expired"}, {15'd0, expired}, 16'd0);
    check({tag, ".buzz"}, {15'd0, buzz}, 16'd0);
    m_st = 0;
    m_sec = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  always @(negedge clk)
    if (!rst_n) exp_d <= 1'b0;
    else begin
      n_cmp++;
      assert (cnt[3:0] <= 4'd9 && cnt[7:4] <= 4'd5 && cnt[11:8] <= 4'd9 && cnt[15:12] <= 4'd5) else begin
        n_bad++;
        $error("FAIL bcd_range observed=%h expected=digits_within_5959", cnt);
      end
      n_cmp++;
      assert (!(expired && exp_d)) else begin
        n_bad++;
        $error("FAIL expired_width observed=2_cycles expected=1_cycle");
      end
      exp_d <= expired;
    end

  initial begin
    #2 rst_n = 0;
    #3;
    check("rst.cnt", cnt, 16'h0000);
    check("rst.running", {15'd0, running}, 16'd0);
    check("rst.expired", {15'd0, expired}, 16'd0);
    check("rst.buzz", {15'd0, buzz}, 16'd0);
    @(negedge clk);
    rst_n = 1;
    cyc("ld0003", 0, 1, 16'h0003, 0, 0, 0);
    cyc("start", 0, 0, 0, 1, 0, 0);
    cyc("tick1", 1, 0, 0, 0, 0, 0);
    check("c0002", cnt, 16'h0002);
    cyc("tick2", 1, 0, 0, 0, 0, 0);
    check("c0001", cnt, 16'h0001);
    cyc("tick3", 1, 0, 0, 0, 0, 0);
    check("exp_pulse", {15'd0, expired}, 16'd1);
    check("buzz_on", {15'd0, buzz}, 16'd1);
    cyc("done_ign", 1, 0, 0, 1, 0, 0);
    check("exp_once", {15'd0, expired}, 16'd0);
    cyc("ack", 0, 0, 0, 0, 0, 1);
    check("buzz_off", {15'd0, buzz}, 16'd0);
    cyc("ld1000", 0, 1, 16'h1000, 0, 0, 0);
    cyc("start2", 0, 0, 0, 1, 0, 0);
    cyc("tick_brw", 1, 0, 0, 0, 0, 0);
    check("c0959", cnt, 16'h0959);
    cyc("stop", 0, 0, 0, 0, 1, 0);
    cyc("ld0100_p", 0, 1, 16'h0100, 0, 0, 0);
    cyc("start3", 0, 0, 0, 1, 0, 0);
    cyc("tick_min", 1, 0, 0, 0, 0, 0);
    check("c0059", cnt, 16'h0059);
    cyc("tick_stop", 1, 0, 0, 0, 1, 0);
    check("ts_cnt", cnt, 16'h0059);
    check("ts_run", {15'd0, running}, 16'd0);
    cyc("tick_pause", 1, 0, 0, 0, 0, 0);
    cyc("start_stop", 0, 0, 0, 1, 1, 0);
    cyc("resume", 0, 0, 0, 1, 0, 0);
    cyc("tick_res", 1, 0, 0, 0, 0, 0);
    check("c0058", cnt, 16'h0058);
    cyc("ld_in_run", 0, 1, 16'h0300, 0, 0, 0);
    check("ld_ign", cnt, 16'h0058);
    cyc("stop2", 0, 0, 0, 0, 1, 0);
    cyc("ld0010", 0, 1, 16'h0010, 0, 0, 0);
    cyc("start4", 0, 0, 0, 1, 0, 0);
    cyc("tick_tens", 1, 0, 0, 0, 0, 0);
    check("c0009", cnt, 16'h0009);
    cyc("stop3", 0, 0, 0, 0, 1, 0);
    cyc("ldFFFF", 0, 1, 16'hFFFF, 0, 0, 0);
    check("c5959", cnt, 16'h5959);
    cyc("start5", 0, 0, 0, 1, 0, 0);
    cyc("tick_max", 1, 0, 0, 0, 0, 0);
    check("c5958", cnt, 16'h5958);
    cyc("stop4", 0, 0, 0, 0, 1, 0);
    cyc("ld7A3F", 0, 1, 16'h7A3F, 0, 0, 0);
    check("c5939", cnt, 16'h5939);
    cyc("ld1234", 0, 1, 16'h1234, 0, 0, 0);
    cyc("start6", 0, 0, 0, 1, 0, 0);
    check("run1234", {15'd0, running}, 16'd1);
    do_reset("rst_run");
    cyc("ld0000", 0, 1, 16'h0000, 0, 0, 0);
    cyc("start_zero", 0, 0, 0, 1, 0, 0);
    check("zero_idle", {15'd0, running}, 16'd0);
    cyc("ld0001", 0, 1, 16'h0001, 0, 0, 0);
    cyc("ld_start", 0, 1, 16'h0002, 1, 0, 0);
    check("ls_run", {15'd0, running}, 16'd0);
    check("ls_cnt", cnt, 16'h0002);
    cyc("start7", 0, 0, 0, 1, 0, 0);
    cyc("tick_a", 1, 0, 0, 0, 0, 0);
    cyc("tick_b", 1, 0, 0, 0, 0, 0);
    cyc("ld_done", 0, 1, 16'h0005, 0, 0, 0);
    check("ld_done_cnt", cnt, 16'h0005);
    check("ld_done_buzz", {15'd0, buzz}, 16'd0);
    cyc("start8", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc("tick_loop", 1, 0, 0, 0, 0, 0);
    check("done2", {15'd0, buzz}, 16'd1);
    do_reset("rst_done");
    cyc("ld0002", 0, 1, 16'h0002, 0, 0, 0);
    cyc("start9", 0, 0, 0, 1, 0, 0);
    cyc("tick_c", 1, 0, 0, 0, 0, 0);
    check("post_rst", cnt, 16'h0001);
    check("sb_empty", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
